mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of mem_control, between the execute stage and the memory controller.
- Accepts one load or store request at a time over a valid/ready handshake and checks alignment and address range.
- Sequences mem_control's read port and two-cycle write protocol (issue, then write-pending).
- Returns a single-cycle response carrying load data or an error code.

Parameters:
- MEM_BASE, 32'h0000_0000, lowest legal byte address.
- MEM_SIZE, 32'h0001_0000, legal window size in bytes; legal iff MEM_BASE <= addr+nbytes-1 < MEM_BASE+MEM_SIZE.
- LOAD_LATENCY, 1, cycles the read address is held before mem_data_r_i is sampled (range 1..4).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready at posedge
- req_store_i  in  1  1=store, 0=load
- req_sext_i  in  1  sign-extend load
- req_acc_i  in  2  `MEM_ACCESS_BYTE/HALFWORD/WORD (const.v); other codes illegal
- req_addr_i  in  32  byte address
- req_data_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse, no backpressure
- rsp_data_o  out  32  load result (0 for stores/errors)
- rsp_err_o  out  2  0=ok, 1=misaligned/illegal acc, 2=access fault
- mem_sext_o, mem_acc_r_o[2], mem_addr_r_o[32]  out  to mem_control read port
- mem_data_r_i  in  32  read data from mem_control
- mem_wr_en_o  out  1  write request to mem_control
- mem_acc_w_o[2], mem_addr_w_o[32], mem_data_w_o[32]  out  write port
- mem_wr_ready_i  in  1  mem_control ready for a write

Behaviour:
- Reset, synchronous on rst_i: state IDLE; req_ready_o=0 during reset, 1 in the first cycle after; rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, mem_wr_en_o=0; all mem_* address/data/acc/sext registers=0.
- Reset mid-operation aborts immediately with no response. A store already issued may complete inside mem_control; this is not this block's concern.
- States: IDLE, LOAD_WAIT, STORE_ISSUE, STORE_PENDING, RESP.
- IDLE:
  - req_ready_o=1.
  - On accept, latch store, sext, acc, addr and data.
  - Check order: illegal acc code or misalignment (half: addr[0]!=0; word: addr[1:0]!=0) gives err=1. Otherwise an out-of-window address gives err=2.
  - Error -> RESP. Else load -> LOAD_WAIT with counter=LOAD_LATENCY. Else store -> STORE_ISSUE.
- Memory outputs are registered from the latched request; mem_addr_* = raw byte address (mem_control applies masking and MAP_ZERO).
- LOAD_WAIT:
  - Read port driven stable; counter decrements each cycle.
  - When counter==1, sample mem_data_r_i into rsp_data_o (already extended by mem_control) -> RESP.
  - Default latency: accept at edge 0, rsp_valid_o high in cycle 2. In general cycle LOAD_LATENCY+1.
- STORE_ISSUE:
  - Write port driven; mem_wr_en_o = mem_wr_ready_i (combinational AND with state).
  - If mem_wr_ready_i=0, remain in STORE_ISSUE.
  - Else -> STORE_PENDING.
- STORE_PENDING:
  - mem_wr_en_o=0.
  - Write port held unchanged, because mem_control commits it this cycle -> RESP.
  - Store with ready: rsp_valid_o in cycle 3 after accept.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, req_ready_o=0 -> IDLE.
  - rsp_data_o and rsp_err_o hold until the next response.
- Throughput: at most one outstanding request; a back-to-back request is accepted the cycle after RESP.
- Window check: 33-bit arithmetic, so addr+nbytes near 2^32 wrap counts as an access fault.
- mem_wr_en_o is never high outside STORE_ISSUE, and never for errored requests.

Test Plan:
- Load word, addr 0x100, mem_data_r_i=0xDEADBEEF, LOAD_LATENCY=1 -> mem_addr_r_o=0x100 in cycle 1; rsp_valid_o cycle 2, rsp_data_o=0xDEADBEEF, err=0.
- Store byte, addr 0x203, data 0xAB, mem_wr_ready_i=1 -> mem_wr_en_o=1 only cycle 1; addr/acc/data held through cycle 2; rsp_valid_o cycle 3, err=0.
- Store word with mem_wr_ready_i low 3 cycles -> stays STORE_ISSUE, mem_wr_en_o=0; rises in the cycle ready=1; rsp_valid_o 2 cycles later.
- Half load at 0x101 -> err=1, rsp_valid_o cycle 1, no mem_wr_en_o. Word at MEM_BASE+MEM_SIZE-2 -> err=1 (misaligned wins). Word at MEM_BASE+MEM_SIZE -> err=2. acc=2'b11 -> err=1.
- rst_i asserted during STORE_PENDING -> next cycle: IDLE, rsp_valid_o=0 throughout, mem_wr_en_o=0, req_ready_o=1 after release.
- LOAD_LATENCY=3, back-to-back loads held valid -> responses spaced 5 cycles apart; req_ready_o low except in IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the execute stage and mem_control.
// Takes one request at a time, checks alignment and window, drives the
// mem_control read port or its two-cycle write protocol, and returns a
// single-cycle response with load data or an error code.
module mem_lsu #(
   parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE     = 32'h0001_0000,
   parameter int          LOAD_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_store_i,
   input  logic        req_sext_i,
   input  logic [1:0]  req_acc_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_data_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic [1:0]  rsp_err_o,
   output logic        mem_sext_o,
   output logic [1:0]  mem_acc_r_o,
   output logic [31:0] mem_addr_r_o,
   input  logic [31:0] mem_data_r_i,
   output logic        mem_wr_en_o,
   output logic [1:0]  mem_acc_w_o,
   output logic [31:0] mem_addr_w_o,
   output logic [31:0] mem_data_w_o,
   input  logic        mem_wr_ready_i
);

   localparam logic [1:0] ACC_BYTE  = 2'b00;
   localparam logic [1:0] ACC_HALF  = 2'b01;
   localparam logic [1:0] ACC_WORD  = 2'b10;
   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_ALIGN = 2'd1;
   localparam logic [1:0] ERR_FAULT = 2'd2;
   localparam logic [2:0] LAT_INIT  = 3'(LOAD_LATENCY);

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_LOAD_WAIT     = 3'd1,
      ST_STORE_ISSUE   = 3'd2,
      ST_STORE_PENDING = 3'd3,
      ST_RESP          = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_err_q, rsp_err_d;
   logic        mem_sext_q, mem_sext_d;
   logic [1:0]  mem_acc_r_q, mem_acc_r_d;
   logic [31:0] mem_addr_r_q, mem_addr_r_d;
   logic [1:0]  mem_acc_w_q, mem_acc_w_d;
   logic [31:0] mem_addr_w_q, mem_addr_w_d;
   logic [31:0] mem_data_w_q, mem_data_w_d;

   logic [32:0] nbytes_s, first_s, last_s, win_lo_s, win_hi_s;
   logic        misalign_s, in_window_s;

   // Alignment/legality and 33-bit window check of the incoming request.
   always_comb begin
      nbytes_s   = 33'd1;
      misalign_s = 1'b0;
      case (req_acc_i)
         ACC_BYTE: begin
            nbytes_s   = 33'd1;
            misalign_s = 1'b0;
         end
         ACC_HALF: begin
            nbytes_s   = 33'd2;
            misalign_s = req_addr_i[0];
         end
         ACC_WORD: begin
            nbytes_s   = 33'd4;
            misalign_s = |req_addr_i[1:0];
         end
         default: begin
            nbytes_s   = 33'd1;
            misalign_s = 1'b1;
         end
      endcase
      first_s     = {1'b0, req_addr_i};
      last_s      = first_s + nbytes_s - 33'd1;
      win_lo_s    = {1'b0, MEM_BASE};
      win_hi_s    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
      in_window_s = (first_s >= win_lo_s) && (last_s < win_hi_s);
   end

   // Next-state and next-register computation for the request sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      mem_sext_d   = mem_sext_q;
      mem_acc_r_d  = mem_acc_r_q;
      mem_addr_r_d = mem_addr_r_q;
      mem_acc_w_d  = mem_acc_w_q;
      mem_addr_w_d = mem_addr_w_q;
      mem_data_w_d = mem_data_w_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (misalign_s) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 32'd0;
                  rsp_err_d   = ERR_ALIGN;
               end else if (!in_window_s) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 32'd0;
                  rsp_err_d   = ERR_FAULT;
               end else if (req_store_i) begin
                  state_d      = ST_STORE_ISSUE;
                  mem_acc_w_d  = req_acc_i;
                  mem_addr_w_d = req_addr_i;
                  mem_data_w_d = req_data_i;
               end else begin
                  state_d      = ST_LOAD_WAIT;
                  cnt_d        = LAT_INIT;
                  mem_sext_d   = req_sext_i;
                  mem_acc_r_d  = req_acc_i;
                  mem_addr_r_d = req_addr_i;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = mem_data_r_i;
               rsp_err_d   = ERR_OK;
            end else begin
               state_d = ST_LOAD_WAIT;
            end
         end
         ST_STORE_ISSUE: begin
            if (mem_wr_ready_i) begin
               state_d = ST_STORE_PENDING;
            end else begin
               state_d = ST_STORE_ISSUE;
            end
         end
         ST_STORE_PENDING: begin
            // Write port stays put: mem_control commits it during this cycle.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_err_d   = ERR_OK;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 32'd0;
         rsp_err_q    <= 2'd0;
         mem_sext_q   <= 1'b0;
         mem_acc_r_q  <= 2'd0;
         mem_addr_r_q <= 32'd0;
         mem_acc_w_q  <= 2'd0;
         mem_addr_w_q <= 32'd0;
         mem_data_w_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         mem_sext_q   <= mem_sext_d;
         mem_acc_r_q  <= mem_acc_r_d;
         mem_addr_r_q <= mem_addr_r_d;
         mem_acc_w_q  <= mem_acc_w_d;
         mem_addr_w_q <= mem_addr_w_d;
         mem_data_w_q <= mem_data_w_d;
      end
   end

   // Ready and write-enable are state decodes, both forced low while in reset.
   assign req_ready_o  = (state_q == ST_IDLE) && !rst_i;
   assign mem_wr_en_o  = (state_q == ST_STORE_ISSUE) && mem_wr_ready_i && !rst_i;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;
   assign mem_sext_o   = mem_sext_q;
   assign mem_acc_r_o  = mem_acc_r_q;
   assign mem_addr_r_o = mem_addr_r_q;
   assign mem_acc_w_o  = mem_acc_w_q;
   assign mem_addr_w_o = mem_addr_w_q;
   assign mem_data_w_o = mem_data_w_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scoreboard bench for mem_lsu (latency 1 and latency 3).
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid, req_store, req_sext;
   logic [1:0]  req_acc;
   logic [31:0] req_addr, req_data;
   logic        req_ready, rsp_valid;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic        mem_sext, mem_wr_en, mem_wr_ready;
   logic [1:0]  mem_acc_r, mem_acc_w;
   logic [31:0] mem_addr_r, mem_data_r, mem_addr_w, mem_data_w;

   logic        req_valid3, req_ready3, rsp_valid3;
   logic [31:0] rsp_data3, mem_data_r3;
   logic [1:0]  rsp_err3;
   logic        mem_sext3, mem_wr_en3;
   logic [1:0]  mem_acc_r3, mem_acc_w3;
   logic [31:0] mem_addr_r3, mem_addr_w3, mem_data_w3;

   int checks;
   int errors;
   int cyc;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  err;
      int          due;
   } exp_t;
   exp_t sb_q[$];

   mem_lsu dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_store_i(req_store), .req_sext_i(req_sext), .req_acc_i(req_acc),
      .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .mem_sext_o(mem_sext), .mem_acc_r_o(mem_acc_r), .mem_addr_r_o(mem_addr_r),
      .mem_data_r_i(mem_data_r),
      .mem_wr_en_o(mem_wr_en), .mem_acc_w_o(mem_acc_w), .mem_addr_w_o(mem_addr_w),
      .mem_data_w_o(mem_data_w), .mem_wr_ready_i(mem_wr_ready)
   );

   mem_lsu #(.LOAD_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid3), .req_ready_o(req_ready3),
      .req_store_i(1'b0), .req_sext_i(1'b0), .req_acc_i(2'b10),
      .req_addr_i(32'h0000_0040), .req_data_i(32'd0),
      .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3), .rsp_err_o(rsp_err3),
      .mem_sext_o(mem_sext3), .mem_acc_r_o(mem_acc_r3), .mem_addr_r_o(mem_addr_r3),
      .mem_data_r_i(mem_data_r3),
      .mem_wr_en_o(mem_wr_en3), .mem_acc_w_o(mem_acc_w3), .mem_addr_w_o(mem_addr_w3),
      .mem_data_w_o(mem_data_w3), .mem_wr_ready_i(1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number: value k during the cycle after the k-th rising edge.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Scoreboard monitor: every response pulse is matched against the queue head.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected cycle=%0d actual data=%h err=%0d expected no response",
                     cyc, rsp_data, rsp_err);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
         end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
         checks++;
         errors++;
         $display("FAIL rsp_missing cycle=%0d actual none expected due=%0d", cyc, sb_q[0].due);
         void'(sb_q.pop_front());
      end
   end

   // Issue one request when the DUT is ready; k is the response cycle after accept.
   task automatic issue(input logic st, input logic sx, input logic [1:0] acc,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] e_data, input logic [1:0] e_err,
                        input int k, input logic expect_rsp);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_store = st;
      req_sext  = sx;
      req_acc   = acc;
      req_addr  = addr;
      req_data  = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (expect_rsp) sb_q.push_back('{e_data, e_err, cyc + k - 1});
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual running expected finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_sext = 1'b0; req_acc = 2'b00;
      req_addr = 32'd0; req_data = 32'd0;
      mem_wr_ready = 1'b1; mem_data_r = 32'd0;
      req_valid3 = 1'b0; mem_data_r3 = 32'h0BAD_F00D;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
      chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_addr_r", mem_addr_r, 32'd0);
      chk("rst_addr_w", mem_addr_w, 32'd0);
      chk("rst_data_w", mem_data_w, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_ready3", {31'd0, req_ready3}, 32'd1);

      // Load word, latency 1: address in cycle 1, response in cycle 2
      mem_data_r = 32'hDEAD_BEEF;
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2'd0, 2, 1'b1);
      @(negedge clk);
      chk("ld_addr_r", mem_addr_r, 32'h0000_0100);
      chk("ld_acc_r", {30'd0, mem_acc_r}, 32'd2);
      chk("ld_ready_busy", {31'd0, req_ready}, 32'd0);
      chk("ld_wr_en", {31'd0, mem_wr_en}, 32'd0);
      wait_drain();
      @(negedge clk);
      mem_data_r = 32'd0;
      chk("rsp_data_hold", rsp_data, 32'hDEAD_BEEF);
      chk("rsp_valid_single", {31'd0, rsp_valid}, 32'd0);

      // Store byte with ready: wr_en only in cycle 1, port held in cycle 2
      mem_wr_ready = 1'b1;
      issue(1'b1, 1'b0, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'd0, 2'd0, 3, 1'b1);
      @(negedge clk);
      chk("sb_wr_en_c1", {31'd0, mem_wr_en}, 32'd1);
      chk("sb_addr_w_c1", mem_addr_w, 32'h0000_0203);
      chk("sb_acc_w_c1", {30'd0, mem_acc_w}, 32'd0);
      chk("sb_data_w_c1", mem_data_w, 32'h0000_00AB);
      @(negedge clk);
      chk("sb_wr_en_c2", {31'd0, mem_wr_en}, 32'd0);
      chk("sb_addr_w_c2", mem_addr_w, 32'h0000_0203);
      chk("sb_acc_w_c2", {30'd0, mem_acc_w}, 32'd0);
      chk("sb_data_w_c2", mem_data_w, 32'h0000_00AB);
      wait_drain();

      // Store word with write-ready low for three cycles
      mem_wr_ready = 1'b0;
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h1234_5678, 32'd0, 2'd0, 6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("sw_wr_en_stall", {31'd0, mem_wr_en}, 32'd0);
      end
      @(posedge clk);
      #1;
      mem_wr_ready = 1'b1;
      @(negedge clk);
      chk("sw_wr_en_go", {31'd0, mem_wr_en}, 32'd1);
      chk("sw_addr_w", mem_addr_w, 32'h0000_0400);
      chk("sw_data_w", mem_data_w, 32'h1234_5678);
      wait_drain();

      // Error cases: response in cycle 1, never a write enable
      issue(1'b0, 1'b0, 2'b01, 32'h0000_0101, 32'd0, 32'd0, 2'd1, 1, 1'b1);
      @(negedge clk);
      chk("err_half_wr_en", {31'd0, mem_wr_en}, 32'd0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_FFFE, 32'd0, 32'd0, 2'd1, 1, 1'b1);
      issue(1'b0, 1'b0, 2'b10, 32'h0001_0000, 32'd0, 32'd0, 2'd2, 1, 1'b1);
      issue(1'b0, 1'b0, 2'b11, 32'h0000_0000, 32'd0, 32'd0, 2'd1, 1, 1'b1);
      issue(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'd0, 32'd0, 2'd2, 1, 1'b1);
      issue(1'b1, 1'b0, 2'b10, 32'h0001_0000, 32'hFFFF_FFFF, 32'd0, 2'd2, 1, 1'b1);
      @(negedge clk);
      chk("err_store_wr_en", {31'd0, mem_wr_en}, 32'd0);
      wait_drain();

      // Legal accesses at the top of the window
      mem_data_r = 32'hFFFF_FF80;
      issue(1'b0, 1'b1, 2'b01, 32'h0000_FFFE, 32'd0, 32'hFFFF_FF80, 2'd0, 2, 1'b1);
      @(negedge clk);
      chk("hl_sext", {31'd0, mem_sext}, 32'd1);
      chk("hl_acc_r", {30'd0, mem_acc_r}, 32'd1);
      chk("hl_addr_r", mem_addr_r, 32'h0000_FFFE);
      wait_drain();
      mem_data_r = 32'h0000_007F;
      issue(1'b0, 1'b0, 2'b00, 32'h0000_FFFF, 32'd0, 32'h0000_007F, 2'd0, 2, 1'b1);
      wait_drain();

      // Reset during STORE_PENDING: no response, back to idle
      mem_wr_ready = 1'b1;
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0800, 32'h55AA_55AA, 32'd0, 2'd0, 3, 1'b0);
      @(negedge clk);
      chk("rs_wr_en_c1", {31'd0, mem_wr_en}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rs_wr_en_pending", {31'd0, mem_wr_en}, 32'd0);
      chk("rs_rsp_valid_pending", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rs_ready_after", {31'd0, req_ready}, 32'd1);
      chk("rs_wr_en_after", {31'd0, mem_wr_en}, 32'd0);
      chk("rs_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
      chk("rs_rsp_data_cleared", rsp_data, 32'd0);
      chk("rs_addr_w_cleared", mem_addr_w, 32'd0);
      repeat (4) @(negedge clk);

      // Latency 3, valid held: responses every 5 cycles, ready only in IDLE
      @(negedge clk);
      req_valid3 = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("l3_rsp_valid", {31'd0, rsp_valid3}, ((i % 5) == 3) ? 32'd1 : 32'd0);
         chk("l3_ready", {31'd0, req_ready3}, ((i % 5) == 4) ? 32'd1 : 32'd0);
         if ((i % 5) == 3) begin
            chk("l3_rsp_data", rsp_data3, 32'h0BAD_F00D);
            chk("l3_rsp_err", {30'd0, rsp_err3}, 32'd0);
         end
      end
      req_valid3 = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
